// File: rtl/cgp_neuron_sched.sv
// cgp_neuron_sched: time-multiplexes one combinational approximate CGP neuron
// core across N_NEURONS logical neurons. It latches a feature vector and walks
// a per-neuron feature-index table to drive the three core operands. The result
// bits are collected into one word, which leaves over a valid/ready handshake.
// Optional build macro: CGP_SCHED_CORE_REG_EN registers the core operands, so
// each neuron is sampled one cycle after its operands are selected.
`timescale 1ns/1ps

module cgp_neuron_sched #(
    parameter int N_NEURONS = 8,
    parameter int N_FEAT    = 8,
    parameter int IN_W      = 3,
    localparam int IDX_W    = $clog2(N_FEAT),
    localparam int ADDR_W   = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*IN_W-1:0]   in_feat,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [3*IDX_W-1:0]       cfg_data,
    output logic                     cfg_err,
    output logic [IN_W-1:0]          core_a,
    output logic [IN_W-1:0]          core_b,
    output logic [IN_W-1:0]          core_c,
    input  logic                     core_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_NEURONS-1:0]     out_bits,
    output logic                     busy
);

`ifdef CGP_SCHED_CORE_REG_EN
    localparam int REG_STAGE = 1;
`else
    localparam int REG_STAGE = 0;
`endif

    localparam int CNT_W = $clog2(N_NEURONS + 1);
    // Counter value of the final RUN cycle; one extra cycle drains the operand register.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_NEURONS - 1 + REG_STAGE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state, state_nxt;
    logic [CNT_W-1:0]          cnt;
    logic [N_FEAT*IN_W-1:0]    feat;
    logic [3*IDX_W-1:0]        tbl [N_NEURONS];
    logic [N_NEURONS-1:0]      bits;

    // A write that coincides with an accepted vector is parked here so that
    // vector still sees the old entry; it lands when the result is delivered.
    logic                      pend_vld;
    logic [ADDR_W-1:0]         pend_addr;
    logic [3*IDX_W-1:0]        pend_data;

    logic                      accept;
    logic                      done_xfer;
    logic                      addr_ok;
    logic                      cfg_ok;
    logic [3*IDX_W-1:0]        cur_ent;
    logic [IN_W-1:0]           sel_a, sel_b, sel_c;
    logic                      samp_en;
    logic [CNT_W-1:0]          samp_idx;

    // Feature lookup; indices at or beyond N_FEAT read as zero.
    function automatic logic [IN_W-1:0] pick(input logic [N_FEAT*IN_W-1:0] fv,
                                             input logic [IDX_W-1:0]       idx);
        pick = '0;
        for (int f = 0; f < N_FEAT; f++) begin
            if (idx == IDX_W'(f)) pick = fv[f*IN_W +: IN_W];
        end
    endfunction

    assign accept    = (state == S_IDLE) && in_valid;
    assign done_xfer = (state == S_DONE) && out_ready;
    assign addr_ok   = ({1'b0, cfg_addr} < (ADDR_W+1)'(N_NEURONS));
    assign cfg_ok    = cfg_we && (state == S_IDLE) && addr_ok;
    assign out_bits  = bits;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Neuron counter and feature latch, both loaded when a vector is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            feat <= '0;
        end else if (accept) begin
            cnt  <= '0;
            feat <= in_feat;
        end else if ((state == S_RUN) && (cnt != LAST_CNT)) begin
            cnt  <= cnt + CNT_W'(1);
        end
    end

    // Table entry of the neuron the counter currently points at.
    always_comb begin
        cur_ent = '0;
        for (int n = 0; n < N_NEURONS; n++) begin
            if (cnt == CNT_W'(n)) cur_ent = tbl[n];
        end
    end

    assign sel_a = pick(feat, cur_ent[0*IDX_W +: IDX_W]);
    assign sel_b = pick(feat, cur_ent[1*IDX_W +: IDX_W]);
    assign sel_c = pick(feat, cur_ent[2*IDX_W +: IDX_W]);

`ifdef CGP_SCHED_CORE_REG_EN
    logic [IN_W-1:0]  core_a_p0, core_b_p0, core_c_p0;
    logic             vld_p0;
    logic [CNT_W-1:0] idx_p0;

    // Operand stage: neuron k's operands are registered, sampled one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_a_p0 <= '0;
            core_b_p0 <= '0;
            core_c_p0 <= '0;
            vld_p0    <= 1'b0;
            idx_p0    <= '0;
        end else if ((state == S_RUN) && (cnt != LAST_CNT)) begin
            core_a_p0 <= sel_a;
            core_b_p0 <= sel_b;
            core_c_p0 <= sel_c;
            vld_p0    <= 1'b1;
            idx_p0    <= cnt;
        end else begin
            core_a_p0 <= '0;
            core_b_p0 <= '0;
            core_c_p0 <= '0;
            vld_p0    <= 1'b0;
            idx_p0    <= '0;
        end
    end

    assign core_a   = core_a_p0;
    assign core_b   = core_b_p0;
    assign core_c   = core_c_p0;
    assign samp_en  = vld_p0;
    assign samp_idx = idx_p0;
`else
    assign core_a   = (state == S_RUN) ? sel_a : '0;
    assign core_b   = (state == S_RUN) ? sel_b : '0;
    assign core_c   = (state == S_RUN) ? sel_c : '0;
    assign samp_en  = (state == S_RUN);
    assign samp_idx = cnt;
`endif

    // Result word: cleared on accept, one bit captured per scheduled neuron.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits <= '0;
        end else if (accept) begin
            bits <= '0;
        end else if (samp_en) begin
            for (int n = 0; n < N_NEURONS; n++) begin
                if (samp_idx == CNT_W'(n)) bits[n] <= core_out;
            end
        end
    end

    // Rejected configuration writes raise a one-cycle error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cfg_err <= 1'b0;
        else        cfg_err <= cfg_we && !((state == S_IDLE) && addr_ok);
    end

    // Index table with the deferred-write slot for same-cycle accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N_NEURONS; n++) tbl[n] <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
        end else begin
            if (cfg_ok && !accept) begin
                for (int n = 0; n < N_NEURONS; n++) begin
                    if (cfg_addr == ADDR_W'(n)) tbl[n] <= cfg_data;
                end
            end
            if (cfg_ok && accept) begin
                pend_vld  <= 1'b1;
                pend_addr <= cfg_addr;
                pend_data <= cfg_data;
            end else if (done_xfer) begin
                pend_vld  <= 1'b0;
            end
            if (done_xfer && pend_vld) begin
                for (int n = 0; n < N_NEURONS; n++) begin
                    if (pend_addr == ADDR_W'(n)) tbl[n] <= pend_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_cgp_neuron_sched.sv
// Bench for cgp_neuron_sched: 8 neurons, 6 features (so index values 6 and 7
// are out of range). A behavioural stand-in for the CGP core answers
// combinationally from the core ports. Expected result words are queued when
// a vector is issued and are popped by a monitor on every out_valid&&out_ready.
`timescale 1ns/1ps

module tb_cgp_neuron_sched;

    localparam int N = 8;
    localparam int F = 6;
`ifdef CGP_SCHED_CORE_REG_EN
    localparam int REG = 1;
`else
    localparam int REG = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_feat;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [8:0]  cfg_data;
    logic        cfg_err;
    logic [2:0]  core_a, core_b, core_c;
    logic        core_out;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_bits;
    logic        busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_q [$];
    logic [8:0]  tb_tbl [N];

    // Feature vectors, feature 5 in the top bits.
    localparam logic [17:0] FI = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [17:0] FA = {3'd3, 3'd6, 3'd1, 3'd5, 3'd2, 3'd7};

    cgp_neuron_sched #(.N_NEURONS(N), .N_FEAT(F), .IN_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err),
        .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .busy(busy)
    );

    // Reference CGP core stand-in: (a > b) xor c[0].
    function automatic logic cgp_ref(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        return (a > b) ^ c[0];
    endfunction

    assign core_out = cgp_ref(core_a, core_b, core_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] feat_of(input logic [17:0] fv, input logic [2:0] idx);
        int i;
        i = int'(idx);
        if (i < F) return fv[i*3 +: 3];
        return 3'd0;
    endfunction

    // Expected {core_a, core_b, core_c} while neuron k is on the core port.
    function automatic logic [8:0] exp_ports(input logic [17:0] fv, input int k);
        logic [8:0] e;
        if (k < 0 || k >= N) return 9'd0;
        e = tb_tbl[k];
        return {feat_of(fv, e[2:0]), feat_of(fv, e[5:3]), feat_of(fv, e[8:6])};
    endfunction

    function automatic logic [8:0] ent(input int a, input int b, input int c);
        return {3'(c), 3'(b), 3'(a)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [8:0] data);
        cfg_we = 1'b1; cfg_addr = addr; cfg_data = data;
        step();
        cfg_we = 1'b0;
        check($sformatf("cfg_err idle write %0d", addr), 32'(cfg_err), 32'd0);
        tb_tbl[addr] = data;
    endtask

    task automatic issue(input logic [17:0] f, input logic [7:0] exp, input bit push);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL issue wait: in_ready 0, expected 1");
        end
        in_valid = 1'b1; in_feat = f;
        if (push) exp_q.push_back(exp);
        step();
        in_valid = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic run_vec(input logic [17:0] f, input logic [7:0] exp);
        int lat;
        lat = 0;
        issue(f, exp, 1'b1);
        for (int m = 0; m < N + REG + 3; m++) begin
            if (m <= N + REG)
                check($sformatf("core ports m=%0d", m), 32'({core_a, core_b, core_c}),
                      32'(exp_ports(f, m - REG)));
            if (out_valid && lat == 0) lat = m + 1;
            step();
        end
        check("accept-to-out_valid latency", 32'(lat), 32'(N + 1 + REG));
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy && w < 40) begin
            step();
            w++;
        end
        check("return to idle", 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: every delivered word is compared with the queue head.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected result: out_bits 0x%0h, expected no out_valid", out_bits);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bits", 32'(out_bits), 32'(e));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int seen;
        for (int n = 0; n < N; n++) tb_tbl[n] = 9'd0;
        rst_n = 1'b0; in_valid = 1'b0; in_feat = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; out_ready = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_feat   = 18'($urandom);
            cfg_we    = 1'($urandom_range(0, 1));
            cfg_addr  = 3'($urandom);
            cfg_data  = 9'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
            check("reset in_ready", 32'(in_ready), 32'd1);
            check("reset out_valid", 32'(out_valid), 32'd0);
            check("reset out_bits", 32'(out_bits), 32'd0);
            check("reset core ports", 32'({core_a, core_b, core_c}), 32'd0);
            check("reset busy", 32'(busy), 32'd0);
            check("reset cfg_err", 32'(cfg_err), 32'd0);
        end
        in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();

        // Identity table with identity features: 0x2A.
        for (int n = 0; n < N; n++) cfg_write(3'(n), ent(n, n, n));
        run_vec(FI, 8'h2A);

        // Backpressure in DONE, with an offered vector and a cfg write that must both be ignored.
        out_ready = 1'b0;
        issue(FA, 8'h2D, 1'b1);
        w = 0;
        while (!out_valid && w < 30) begin
            step();
            w++;
        end
        check("out_valid under backpressure", 32'(out_valid), 32'd1);
        in_valid = 1'b1; in_feat = FI;
        for (int i = 0; i < 20; i++) begin
            check("hold out_valid", 32'(out_valid), 32'd1);
            check("hold out_bits", 32'(out_bits), 32'h2D);
            check("hold in_ready", 32'(in_ready), 32'd0);
            if (i == 5) begin
                cfg_we = 1'b1; cfg_addr = 3'd2; cfg_data = 9'h1FF;
            end
            step();
            if (i == 5) begin
                cfg_we = 1'b0;
                check("cfg_err done write", 32'(cfg_err), 32'd1);
            end
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("out_valid after release", 32'(out_valid), 32'd0);
        check("in_ready after release", 32'(in_ready), 32'd1);
        check("no same-cycle accept", 32'(busy), 32'd0);
        run_vec(FI, 8'h2A);

        // Mixed table with out-of-range indices in entries 5..7: 0x1E.
        cfg_write(3'd0, ent(0, 1, 2));
        cfg_write(3'd1, ent(1, 0, 3));
        cfg_write(3'd2, ent(2, 3, 4));
        cfg_write(3'd3, ent(5, 4, 0));
        cfg_write(3'd4, ent(3, 3, 5));
        cfg_write(3'd5, ent(7, 0, 1));
        cfg_write(3'd6, ent(4, 6, 2));
        cfg_write(3'd7, ent(5, 2, 7));
        run_vec(FA, 8'h1E);

        // Config write during RUN is dropped with a one-cycle error pulse.
        issue(FA, 8'h1E, 1'b1);
        step();
        cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 9'h1FF;
        step();
        cfg_we = 1'b0;
        check("cfg_err run write", 32'(cfg_err), 32'd1);
        step();
        check("cfg_err pulse width", 32'(cfg_err), 32'd0);
        wait_idle();
        run_vec(FA, 8'h1E);

        // Same-cycle write and accept: old entry for this vector, new one for the next.
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = ent(3, 5, 0);
        run_vec(FA, 8'h1E);
        tb_tbl[0] = ent(3, 5, 0);
        run_vec(FA, 8'h1F);

        // Reset in RUN cycle 4: nothing is emitted and the table returns to zero.
        issue(FA, 8'h00, 1'b0);
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("mid-run reset out_valid", 32'(out_valid), 32'd0);
        check("mid-run reset busy", 32'(busy), 32'd0);
        check("mid-run reset in_ready", 32'(in_ready), 32'd1);
        check("mid-run reset core ports", 32'({core_a, core_b, core_c}), 32'd0);
        check("mid-run reset out_bits", 32'(out_bits), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen++;
            step();
        end
        check("no out_valid after mid-run reset", 32'(seen), 32'd0);
        for (int n = 0; n < N; n++) tb_tbl[n] = 9'd0;
        run_vec(FA, 8'hFF);

        repeat (3) step();
        check("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
